// File: rtl/ledr_pwm_pkg.sv
// Register map constants and address decode shared by the ledr_pwm_pio block.
package ledr_pwm_pkg;

    localparam logic [4:0]  ADDR_OUT       = 5'd0;
    localparam logic [4:0]  ADDR_MODE      = 5'd1;
    localparam logic [4:0]  ADDR_PRESC     = 5'd2;
    localparam logic [4:0]  ADDR_INFO      = 5'd3;
    localparam logic [4:0]  ADDR_DUTY_BASE = 5'd16;
    localparam logic [15:0] INFO_MAGIC     = 16'h1ED0;
    localparam int unsigned NUM_CH_MAX     = 16;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_OUT,
        SEL_MODE,
        SEL_PRESC,
        SEL_INFO,
        SEL_DUTY
    } reg_sel_e;

    // DUTY slots beyond the configured channel count decode as unmapped.
    function automatic reg_sel_e decode_addr(input logic [4:0] addr, input int unsigned num_ch);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (addr == ADDR_OUT)
            sel = SEL_OUT;
        else if (addr == ADDR_MODE)
            sel = SEL_MODE;
        else if (addr == ADDR_PRESC)
            sel = SEL_PRESC;
        else if (addr == ADDR_INFO)
            sel = SEL_INFO;
        else if (addr >= ADDR_DUTY_BASE && 32'(addr - ADDR_DUTY_BASE) < num_ch)
            sel = SEL_DUTY;
        return sel;
    endfunction

endpackage

// File: rtl/ledr_pwm_ch.sv
// One LED channel: duty register, comparator, PIO/PWM mux and output flop.
// LEDR_PWM_SYNC_UPDATE_EN adds a shadow duty register applied at period end.
module ledr_pwm_ch
    import ledr_pwm_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                duty_we,
    input  logic [PWM_BITS-1:0] duty_wdata,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                period_end,
    input  logic                pwm_mode,
    input  logic                pio_val,
    output logic [PWM_BITS-1:0] duty_rdata,
    output logic                led
);

    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                led_q, led_d;

`ifdef LEDR_PWM_SYNC_UPDATE_EN
    logic [PWM_BITS-1:0] shadow_q, shadow_d;

    // A write coinciding with period_end lands in the shadow and waits one more period.
    always_comb begin
        shadow_d = shadow_q;
        duty_d   = duty_q;
        if (duty_we)
            shadow_d = duty_wdata;
        if (period_end)
            duty_d = shadow_q;
    end

    always_ff @(posedge clk) begin
        if (rst)
            shadow_q <= '0;
        else
            shadow_q <= shadow_d;
    end

    assign duty_rdata = shadow_q;
`else
    logic unused_period_end;
    assign unused_period_end = period_end;

    always_comb begin
        duty_d = duty_q;
        if (duty_we)
            duty_d = duty_wdata;
    end

    assign duty_rdata = duty_q;
`endif

    always_comb begin
        led_d = pio_val;
        if (pwm_mode)
            led_d = (pwm_cnt < duty_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= '0;
            led_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            led_q  <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/ledr_pwm_pio.sv
// Avalon-MM LED PIO/PWM controller: bus decode, readback, prescaler and PWM counter.
// Optional build macro: LEDR_PWM_SYNC_UPDATE_EN (period-aligned duty updates).
module ledr_pwm_pio
    import ledr_pwm_pkg::*;
#(
    parameter int unsigned NUM_CH   = 10,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned PRESC_W  = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [4:0]        avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    output logic [NUM_CH-1:0] ledr_export
);

    if (NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
        $error("ledr_pwm_pio: NUM_CH exceeds NUM_CH_MAX");
    end

    reg_sel_e            sel;
    logic [NUM_CH-1:0]   out_q, out_d;
    logic [NUM_CH-1:0]   mode_q, mode_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [PRESC_W-1:0]  presc_cnt_q, presc_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                tick;
    logic                period_end;
    logic [NUM_CH-1:0]   duty_we;
    logic [NUM_CH-1:0]   led;
    logic [PWM_BITS-1:0] duty_rdata [NUM_CH];
    logic                unused_wdata;

    assign unused_wdata = ^avs_writedata;
    assign sel          = decode_addr(avs_address, NUM_CH);

    always_comb begin
        out_d   = out_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        duty_we = '0;
        if (avs_write) begin
            case (sel)
                SEL_OUT:   out_d   = avs_writedata[NUM_CH-1:0];
                SEL_MODE:  mode_d  = avs_writedata[NUM_CH-1:0];
                SEL_PRESC: presc_d = avs_writedata[PRESC_W-1:0];
                SEL_DUTY: begin
                    for (int unsigned k = 0; k < NUM_CH; k++)
                        duty_we[k] = (avs_address[3:0] == 4'(k));
                end
                default: ;
            endcase
        end
    end

    // >= rather than == so lowering PRESC below the running count wraps at once.
    always_comb begin
        tick        = (presc_cnt_q >= presc_q);
        presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_W'(1);
        pwm_cnt_d   = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        period_end  = tick && (pwm_cnt_q == '1);
    end

    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            rdata_d = '0;
            case (sel)
                SEL_OUT:   rdata_d = 32'(out_q);
                SEL_MODE:  rdata_d = 32'(mode_q);
                SEL_PRESC: rdata_d = 32'(presc_q);
                SEL_INFO:  rdata_d = {INFO_MAGIC, 8'(PWM_BITS), 8'(NUM_CH)};
                SEL_DUTY: begin
                    for (int unsigned k = 0; k < NUM_CH; k++)
                        if (avs_address[3:0] == 4'(k))
                            rdata_d = 32'(duty_rdata[k]);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            out_q       <= '0;
            mode_q      <= '0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            rdata_q     <= '0;
        end else begin
            out_q       <= out_d;
            mode_q      <= mode_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            rdata_q     <= rdata_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        ledr_pwm_ch #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk        (clk_clk),
            .rst        (reset_reset),
            .duty_we    (duty_we[k]),
            .duty_wdata (avs_writedata[PWM_BITS-1:0]),
            .pwm_cnt    (pwm_cnt_q),
            .period_end (period_end),
            .pwm_mode   (mode_q[k]),
            .pio_val    (out_q[k]),
            .duty_rdata (duty_rdata[k]),
            .led        (led[k])
        );
    end

    assign ledr_export  = led;
    assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_ledr_pwm_pio.sv
// Scoreboard bench for ledr_pwm_pio: stimulus queues expectations, a monitor compares.
module tb_ledr_pwm_pio;
    import ledr_pwm_pkg::*;

    localparam int unsigned NUM_CH   = 10;
    localparam int unsigned PWM_BITS = 8;
    localparam int unsigned PRESC_W  = 16;

    logic              clk_clk       = 1'b0;
    logic              reset_reset   = 1'b1;
    logic [4:0]        avs_address   = '0;
    logic              avs_write     = 1'b0;
    logic [31:0]       avs_writedata = '0;
    logic              avs_read      = 1'b0;
    logic [31:0]       avs_readdata;
    logic [NUM_CH-1:0] ledr_export;

    always #5 clk_clk = ~clk_clk;

    ledr_pwm_pio #(
        .NUM_CH  (NUM_CH),
        .PWM_BITS(PWM_BITS),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .avs_address  (avs_address),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .ledr_export  (ledr_export)
    );

    typedef struct {
        string       name;
        logic [31:0] exp;
        logic [31:0] mask;
        bit          is_rd;
    } samp_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_t;

    typedef struct {
        string name;
        int    ch;
        int    len;
        int    exp;
    } win_t;

    samp_t sq[$];
    rd_t   rq[$];
    win_t  wq[$];

    int    n_checks = 0;
    int    n_pass   = 0;
    logic  rd_vld   = 1'b0;
    win_t  cur_w;
    int    win_left = 0;
    int    win_acc  = 0;
    rd_t   mon_r;
    samp_t mon_s;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    // Monitor: read data is valid the cycle after the strobe; LED samples and windows every cycle.
    always @(posedge clk_clk) rd_vld <= avs_read;

    always @(negedge clk_clk) begin
        if (rd_vld) begin
            if (rq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_read: got 0x%0h, expected no read", avs_readdata);
            end else begin
                mon_r = rq.pop_front();
                check(mon_r.name, avs_readdata, mon_r.exp);
            end
        end
        while (sq.size() > 0) begin
            mon_s = sq.pop_front();
            check(mon_s.name, (mon_s.is_rd ? avs_readdata : 32'(ledr_export)) & mon_s.mask,
                  mon_s.exp & mon_s.mask);
        end
        if (win_left > 0) begin
            win_acc += int'(ledr_export[cur_w.ch]);
            win_left--;
            if (win_left == 0)
                check(cur_w.name, 32'(win_acc), 32'(cur_w.exp));
        end else if (wq.size() > 0) begin
            cur_w    = wq.pop_front();
            win_acc  = int'(ledr_export[cur_w.ch]);
            win_left = cur_w.len - 1;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        step();
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        step();
        avs_write     = 1'b0;
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        step();
        avs_address = a;
        avs_read    = 1'b1;
        rq.push_back('{name, exp});
        step();
        avs_read    = 1'b0;
    endtask

    task automatic rdwr(input string name, input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] exp_old);
        step();
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        rq.push_back('{name, exp_old});
        step();
        avs_write     = 1'b0;
        avs_read      = 1'b0;
    endtask

    task automatic samp(input string name, input logic [31:0] exp, input logic [31:0] mask,
                        input bit is_rd);
        sq.push_back('{name, exp, mask, is_rd});
    endtask

    task automatic win(input string name, input int ch, input int len, input int exp);
        wq.push_back('{name, ch, len, exp});
        step(len + 3);
    endtask

    task automatic wait_rise(input int ch, input int budget, output bit ok);
        logic prev;
        ok   = 1'b0;
        prev = ledr_export[ch];
        for (int i = 0; i < budget; i++) begin
            step();
            if (ledr_export[ch] && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = ledr_export[ch];
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish within 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;

        reset_reset = 1'b1;
        step();
        samp("rst_led_a", 32'h0, '1, 1'b0);
        samp("rst_rdata_a", 32'h0, '1, 1'b1);
        step();
        samp("rst_led_b", 32'h0, '1, 1'b0);
        samp("rst_rdata_b", 32'h0, '1, 1'b1);
        step();
        reset_reset = 1'b0;

        rd("info", ADDR_INFO, 32'h1ED0_080A);

        // PIO path: upper writedata bits dropped, pin follows two clocks after the strobe
        wr(ADDR_OUT, 32'hFFFF_F2A5);
        samp("out_pin_1clk", 32'h0, '1, 1'b0);
        step();
        samp("out_pin_2clk", 32'h2A5, '1, 1'b0);
        rd("out_rb", ADDR_OUT, 32'h2A5);
        rdwr("rdwr_old", ADDR_OUT, 32'h155, 32'h2A5);
        rd("rdwr_new", ADDR_OUT, 32'h155);
        samp("rdwr_pin", 32'h155, '1, 1'b0);

        // Unmapped addresses
        wr(5'd28, 32'hFFFF_FFFF);
        wr(5'd7, 32'hFFFF_FFFF);
        rd("unmap28", 5'd28, 32'h0);
        rd("unmap7", 5'd7, 32'h0);
        rd("out_after_unmap", ADDR_OUT, 32'h155);
        rd("mode_after_unmap", ADDR_MODE, 32'h0);
        rd("duty0_after_unmap", ADDR_DUTY_BASE, 32'h0);
        samp("pin_after_unmap", 32'h155, '1, 1'b0);

        // PWM with PRESC=0: one count per cycle, 256-cycle period
        wr(ADDR_DUTY_BASE, 32'd64);
        wr(ADDR_DUTY_BASE + 5'd1, 32'd0);
        wr(ADDR_DUTY_BASE + 5'd2, 32'hFFFF_FFFF);
        wr(ADDR_MODE, 32'h7);
        step(300);
        rd("duty0_rb", ADDR_DUTY_BASE, 32'd64);
        rd("duty2_rb", ADDR_DUTY_BASE + 5'd2, 32'd255);
        rd("mode_rb", ADDR_MODE, 32'h7);
        rd("presc_rb0", ADDR_PRESC, 32'h0);
        samp("pio_ch_hold", 32'h155, 32'h3F8, 1'b0);
        win("pwm_ch0_64", 0, 256, 64);
        win("pwm_ch1_0", 1, 256, 0);
        win("pwm_ch2_255", 2, 256, 255);

        // PRESC=3: four cycles per count, 1024-cycle period
        wr(ADDR_PRESC, 32'd3);
        step(10);
        win("presc3_ch0", 0, 1024, 256);

        // Lower PRESC below a running count: must wrap rather than run away
        wr(ADDR_PRESC, 32'd3000);
        step(100);
        wr(ADDR_PRESC, 32'd1);
        step(4);
        win("presc1_ch0", 0, 512, 128);
        rd("presc_rb1", ADDR_PRESC, 32'd1);

        // Duty change mid-period
        wr(ADDR_PRESC, 32'd0);
        step(4);
        wait_rise(0, 600, ok);
        if (!ok) begin
            n_checks++;
            $display("FAIL ch0_rise: got no rising edge, expected one within 600 cycles");
        end
        step(100);
        wr(ADDR_DUTY_BASE, 32'd128);
        step(10);
`ifdef LEDR_PWM_SYNC_UPDATE_EN
        samp("duty_mid_period", 32'h0, 32'h1, 1'b0);
`else
        samp("duty_mid_period", 32'h1, 32'h1, 1'b0);
`endif
        rd("duty0_rb128", ADDR_DUTY_BASE, 32'd128);
        step(300);
        win("pwm_ch0_128", 0, 256, 128);

        // Reset mid-run
        wr(ADDR_MODE, 32'h0);
        wr(ADDR_OUT, 32'h3FF);
        step(3);
        samp("pre_reset_pin", 32'h3FF, '1, 1'b0);
        step();
        reset_reset = 1'b1;
        step(2);
        samp("rst_mid_pin", 32'h0, '1, 1'b0);
        samp("rst_mid_rdata", 32'h0, '1, 1'b1);
        reset_reset = 1'b0;
        rd("rst_out", ADDR_OUT, 32'h0);
        rd("rst_mode", ADDR_MODE, 32'h0);
        rd("rst_duty0", ADDR_DUTY_BASE, 32'h0);
        rd("rst_presc", ADDR_PRESC, 32'h0);
        step(3);
        samp("post_rst_pin", 32'h0, '1, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            if (sq.size() == 0 && rq.size() == 0 && wq.size() == 0 && win_left == 0)
                break;
            step();
        end
        step(2);
        if (sq.size() != 0 || rq.size() != 0 || wq.size() != 0 || win_left != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending items, expected 0",
                     sq.size() + rq.size() + wq.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
